mp_add_sequencer: RTL and testbench
===================================

Name: mp_add_sequencer

Overview:
- Multi-precision adder sequencer. Adds two WIDTH*WORDS-bit operands by issuing one WIDTH-bit word per cycle to an external WIDTH-bit adder core, least-significant word first.
- Drives the core's A/B/Cin and consumes its S/Cout.
- The carry between words is held in a register, so the core's combinational depth stays at one word.
- Sits between operand producers (valid/ready) and result consumers (valid/ready).

Parameters:
- WIDTH, 32, width of one adder-core word.
- WORDS, 4, number of words per operand; total operand width is WIDTH*WORDS; legal range 1..16.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand request valid.
- in_ready  output  1  sequencer can accept an operand request.
- A  input  WIDTH*WORDS  operand A.
- B  input  WIDTH*WORDS  operand B.
- Cin  input  1  carry into word 0.
- core_A  output  WIDTH  word driven to the adder core.
- core_B  output  WIDTH  word driven to the adder core.
- core_Cin  output  1  carry driven to the adder core.
- core_S  input  WIDTH  sum returned by the adder core (combinational from core_A/B/Cin).
- core_Cout  input  1  carry returned by the adder core.
- S  output  WIDTH*WORDS  full-width result.
- Cout  output  1  carry out of the most-significant word.
- out_valid  output  1  S/Cout valid.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Clock is clk; reset rst is synchronous and active-high. Single clock domain.
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: S=0, Cout=0, out_valid=0, word index k=0, carry_q=0, operand latches=0.
- in_ready = (state==IDLE). It is decoded from state, so it reads 1 in the cycle after reset deasserts.
- IDLE:
  - in_valid&&in_ready latches A, B into internal registers, sets carry_q<=Cin and k<=0, and moves to RUN.
  - A, B and Cin are don't-care outside the accept cycle.
- RUN, each cycle:
  - core_A = A_q[k*WIDTH +: WIDTH], core_B = B_q[k*WIDTH +: WIDTH], core_Cin = carry_q.
  - At the edge: S[k*WIDTH +: WIDTH] <= core_S, carry_q <= core_Cout, k <= k+1.
  - When k==WORDS-1: Cout <= core_Cout, out_valid <= 1, move to DONE; k wraps to 0.
- RUN occupies exactly WORDS cycles. out_valid rises WORDS cycles after the accept edge (WORDS=1: the edge after the accept edge).
- In IDLE and DONE, core_A=0, core_B=0, core_Cin=0, so the core does not toggle.
- DONE:
  - S, Cout and out_valid are held stable while out_ready=0.
  - out_valid&&out_ready clears out_valid and moves to IDLE. S and Cout keep their last values until the next RUN overwrites them.
- in_valid is ignored outside IDLE. There is no same-cycle restart: at least one idle cycle separates transactions.
- Result is the unsigned sum A+B+Cin mod 2^(WIDTH*WORDS), with Cout as bit WIDTH*WORDS.
- Reset mid-RUN or mid-DONE:
  - Aborts the transaction and discards partial S; all registers return to reset values.
  - No out_valid pulse is produced.
- The core path must settle within one clk period; the sequencer adds no extra pipeline stage.

Optional Feature:
- Macro: MP_ADD_SEQ_OVF_EN.
- Defined:
  - Adds output port Ovf (1 bit), the two's-complement signed overflow of the full-width add.
  - Ovf is registered with Cout on the last RUN cycle: Ovf = (A_q msb == B_q msb) && (core_S msb != A_q msb).
  - Ovf resets to 0, is held in DONE, and is valid when out_valid=1.
- Not defined: port Ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WORDS=4, A=0x00000000_00000000_00000000_FFFFFFFF, B=1, Cin=0 -> S=0x00000000_00000000_00000001_00000000, Cout=0; out_valid rises exactly 4 cycles after the accept edge.
- A=all ones (128 bits), B=0, Cin=1 -> S=0, Cout=1; core_Cin observed as 1 in all 4 RUN cycles.
- Result backpressure: out_ready=0 for 3 cycles after out_valid rises, and in_valid=1 with new operands during that time:
  - S, Cout stable; in_ready=0; new operands not accepted.
  - out_ready=1 -> IDLE; in_ready=1 next cycle.
- rst=1 asserted during RUN at k=2 -> next cycle: state IDLE, out_valid=0, S=0, Cout=0, in_ready=1; no stale result appears afterwards.
- WORDS=1, A=0xFFFFFFFF, B=0x00000001, Cin=0 -> S=0x00000000, Cout=1, out_valid on the edge after accept.
- With MP_ADD_SEQ_OVF_EN, WORDS=4:
  - A=0x7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, B=1 -> S=0x80000000_00000000_00000000_00000000, Ovf=1, Cout=0.
  - A=B=all ones -> Ovf=0, Cout=1.

Source files
------------

// File: rtl/mp_add_sequencer.sv
// Multi-precision adder sequencer: streams WIDTH-bit words of A/B into an external adder core, LS word first.
// Latency: result valid WORDS cycles after the accept edge; the core sees one word per cycle.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, and in_valid is ignored meanwhile.
//
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   in_valid/in_ready      - operand handshake carrying A, B, Cin
//   core_A/B/Cin           - word presented to the external adder core (zero when not running)
//   core_S/Cout            - combinational result of the external core
//   S, Cout, out_valid     - full-width result, handshake completed by out_ready
// Optional build macro MP_ADD_SEQ_OVF_EN adds output Ovf (signed overflow of the full add).
module mp_add_sequencer #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] A,
    input  logic [WIDTH*WORDS-1:0] B,
    input  logic                   Cin,
    output logic [WIDTH-1:0]       core_A,
    output logic [WIDTH-1:0]       core_B,
    output logic                   core_Cin,
    input  logic [WIDTH-1:0]       core_S,
    input  logic                   core_Cout,
    output logic [WIDTH*WORDS-1:0] S,
    output logic                   Cout,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef MP_ADD_SEQ_OVF_EN
    ,
    output logic                   Ovf
`endif
);

    localparam int TOTAL = WIDTH * WORDS;
    // Word index needs at least one bit even for a single-word configuration.
    localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [KW-1:0]    r_k;
    logic             r_carry;
    logic [TOTAL-1:0] r_a;
    logic [TOTAL-1:0] r_b;
    logic [TOTAL-1:0] r_s;
    logic             r_cout;
    logic             r_out_valid;

    logic             w_run;
    logic             w_last;
    logic [31:0]      w_base;

    assign w_run  = (r_state == ST_RUN);
    assign w_last = (r_k == KW'(WORDS - 1));
    assign w_base = 32'(r_k) * 32'(WIDTH);

    // Core inputs are forced to zero outside RUN so the core does not toggle.
    assign core_A   = w_run ? r_a[w_base +: WIDTH] : '0;
    assign core_B   = w_run ? r_b[w_base +: WIDTH] : '0;
    assign core_Cin = w_run ? r_carry : 1'b0;

    assign in_ready  = (r_state == ST_IDLE);
    assign S         = r_s;
    assign Cout      = r_cout;
    assign out_valid = r_out_valid;

`ifdef MP_ADD_SEQ_OVF_EN
    logic r_ovf;
    assign Ovf = r_ovf;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef MP_ADD_SEQ_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_carry <= Cin;
                        r_k     <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // One word of the result per cycle; the inter-word carry is registered.
                    r_s[w_base +: WIDTH] <= core_S;
                    r_carry              <= core_Cout;
                    if (w_last) begin
                        r_k         <= '0;
                        r_cout      <= core_Cout;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
`ifdef MP_ADD_SEQ_OVF_EN
                        // Same-sign operands producing a different-sign result overflow.
                        r_ovf       <= (r_a[TOTAL-1] == r_b[TOTAL-1]) &&
                                       (core_S[WIDTH-1] != r_a[TOTAL-1]);
`endif
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Self-checking bench for mp_add_sequencer: a WORDS=4 instance checked every cycle against a
// transaction-level arithmetic model, plus a WORDS=1 instance checked with directed cases.
module tb_mp_add_sequencer;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int TW = W * N;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // WORDS=4 instance
    logic          in_valid, in_ready, cin_in, out_valid, out_ready, cout_out;
    logic [TW-1:0] a_in, b_in, s_out;
    logic [W-1:0]  core_a, core_b, core_s;
    logic          core_cin, core_cout;
    // WORDS=1 instance
    logic          in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1;
    logic [W-1:0]  a1, b1, s1;
    logic [W-1:0]  core_a1, core_b1, core_s1;
    logic          core_cin1, core_cout1;
`ifdef MP_ADD_SEQ_OVF_EN
    logic          ovf_out, ovf1;
`endif

    // External adder cores
    assign {core_cout, core_s}   = {1'b0, core_a} + {1'b0, core_b} + (W+1)'(core_cin);
    assign {core_cout1, core_s1} = {1'b0, core_a1} + {1'b0, core_b1} + (W+1)'(core_cin1);

    mp_add_sequencer #(.WIDTH(W), .WORDS(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a_in), .B(b_in), .Cin(cin_in),
        .core_A(core_a), .core_B(core_b), .core_Cin(core_cin),
        .core_S(core_s), .core_Cout(core_cout),
        .S(s_out), .Cout(cout_out), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MP_ADD_SEQ_OVF_EN
        , .Ovf(ovf_out)
`endif
    );

    mp_add_sequencer #(.WIDTH(W), .WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .A(a1), .B(b1), .Cin(cin1),
        .core_A(core_a1), .core_B(core_b1), .core_Cin(core_cin1),
        .core_S(core_s1), .core_Cout(core_cout1),
        .S(s1), .Cout(cout1), .out_valid(out_valid1), .out_ready(out_ready1)
`ifdef MP_ADD_SEQ_OVF_EN
        , .Ovf(ovf1)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cin_ones = 0;

    task automatic chk(input string name, input logic [TW:0] act, input logic [TW:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    // Carry into word j of A+B+c, from plain arithmetic on the low j words.
    function automatic logic cin_at(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                    input logic c, input int j);
        logic [TW:0] mask;
        logic [TW:0] s;
        if (j == 0) return c;
        mask = ((TW+1)'(1) << (j * W)) - (TW+1)'(1);
        s    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + (TW+1)'(c);
        return s[j * W];
    endfunction

    // Transaction-level model of the WORDS=4 instance.
    bit            m_started = 0;
    bit            m_busy = 0, m_run = 0, m_done = 0;
    int            m_cnt = 0;
    logic [TW-1:0] m_a = '0, m_b = '0;
    logic          m_c = 1'b0;
    logic [TW:0]   m_sum;
    logic [TW-1:0] e_s = '0;
    logic          e_c = 1'b0, e_ovf = 1'b0;

    always @(posedge clk) begin
        m_started = 1;
        if (rst) begin
            m_busy = 0; m_run = 0; m_done = 0; m_cnt = 0;
            e_s = '0; e_c = 1'b0; e_ovf = 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1; m_run = 1; m_cnt = 0;
                m_a = a_in; m_b = b_in; m_c = cin_in;
            end
        end else if (m_run) begin
            m_cnt++;
            if (m_cnt == N) begin
                m_run  = 0;
                m_done = 1;
                m_sum  = {1'b0, m_a} + {1'b0, m_b} + (TW+1)'(m_c);
                e_s    = m_sum[TW-1:0];
                e_c    = m_sum[TW];
                e_ovf  = (m_a[TW-1] == m_b[TW-1]) && (m_sum[TW-1] != m_a[TW-1]);
            end
        end else if (m_done && out_ready) begin
            m_done = 0;
            m_busy = 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            chk("in_ready", in_ready, !m_busy);
            chk("out_valid", out_valid, m_done);
            chk("core_A", core_a, m_run ? m_a[m_cnt*W +: W] : '0);
            chk("core_B", core_b, m_run ? m_b[m_cnt*W +: W] : '0);
            chk("core_Cin", core_cin, m_run ? cin_at(m_a, m_b, m_c, m_cnt) : 1'b0);
            if (!m_run) begin
                chk("S", s_out, e_s);
                chk("Cout", cout_out, e_c);
`ifdef MP_ADD_SEQ_OVF_EN
                chk("Ovf", ovf_out, e_ovf);
`endif
            end
            if (core_cin === 1'b1) cin_ones++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [TW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic c);
        int g = 0;
        while (m_busy && g < 100) begin
            step(1);
            g++;
        end
        if (g >= 100) timeout_fail("send");
        in_valid = 1'b1; a_in = a; b_in = b; cin_in = c;
        step(1);
        in_valid = 1'b0; a_in = rnd128(); b_in = rnd128(); cin_in = 1'($urandom);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            step(1);
            n++;
        end
        if (n >= 50) timeout_fail("wait_valid");
    endtask

    task automatic release_result(input int hold);
        step(hold);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
    endtask

    task automatic run1(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] exp;
        exp = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        in_valid1 = 1'b1; a1 = a; b1 = b; cin1 = c;
        step(1);
        in_valid1 = 1'b0; a1 = $urandom; b1 = $urandom;
        chk("w1_valid_early", out_valid1, 1'b0);
        step(1);
        chk("w1_valid", out_valid1, 1'b1);
        chk("w1_S", s1, exp[W-1:0]);
        chk("w1_Cout", cout1, exp[W]);
        out_ready1 = 1'b1;
        step(1);
        out_ready1 = 1'b0;
        chk("w1_valid_clr", out_valid1, 1'b0);
        chk("w1_in_ready", in_ready1, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_S", s_out, 128'h0);

        // Carry ripple from word 0 into word 1, latency of WORDS cycles.
        send(128'hFFFFFFFF, 128'h1, 1'b0);
        wait_valid(n);
        chk("t1_latency", n, 4);
        chk("t1_S", s_out, 128'h00000000_00000000_00000001_00000000);
        chk("t1_Cout", cout_out, 1'b0);
        release_result(0);

        // Full-width ripple driven only by Cin.
        cin_ones = 0;
        send({TW{1'b1}}, 128'h0, 1'b1);
        wait_valid(n);
        chk("t2_cin_cycles", cin_ones, 4);
        chk("t2_S", s_out, 128'h0);
        chk("t2_Cout", cout_out, 1'b1);
        release_result(0);

        // Result backpressure with competing operand requests.
        send(128'h00000001_00000002_00000003_00000004,
             128'h00000010_00000020_00000030_00000040, 1'b0);
        wait_valid(n);
        in_valid = 1'b1; a_in = rnd128(); b_in = rnd128();
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("bp_S", s_out, 128'h00000011_00000022_00000033_00000044);
            chk("bp_Cout", cout_out, 1'b0);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("bp_idle_in_ready", in_ready, 1'b1);
        chk("bp_S_held", s_out, 128'h00000011_00000022_00000033_00000044);

        // Reset in the middle of RUN (word index 2).
        send(rnd128(), rnd128(), 1'($urandom));
        step(2);
        rst = 1'b1;
        step(1);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_S", s_out, 128'h0);
        chk("abort_Cout", cout_out, 1'b0);
        rst = 1'b0;
        step(8);

        // Single-word configuration.
        run1(32'hFFFFFFFF, 32'h00000001, 1'b0);
        chk("w1_lit_S", s1, 32'h0);
        chk("w1_lit_Cout", cout1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            run1($urandom, $urandom, 1'($urandom));
            step($urandom_range(0, 2));
        end

`ifdef MP_ADD_SEQ_OVF_EN
        send(128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0);
        wait_valid(n);
        chk("ovf1_S", s_out, 128'h80000000_00000000_00000000_00000000);
        chk("ovf1_Ovf", ovf_out, 1'b1);
        chk("ovf1_Cout", cout_out, 1'b0);
        release_result(1);
        send({TW{1'b1}}, {TW{1'b1}}, 1'b0);
        wait_valid(n);
        chk("ovf2_Ovf", ovf_out, 1'b0);
        chk("ovf2_Cout", cout_out, 1'b1);
        release_result(0);
`endif

        // Randomized traffic, with occasional saturated operands.
        for (int i = 0; i < 40; i++) begin
            logic [TW-1:0] ra, rb;
            ra = ($urandom_range(0, 5) == 0) ? {TW{1'b1}} : rnd128();
            rb = ($urandom_range(0, 5) == 0) ? 128'h1 : rnd128();
            send(ra, rb, 1'($urandom));
            wait_valid(n);
            chk("rnd_latency", n, 4);
            release_result($urandom_range(0, 3));
            step($urandom_range(0, 2));
        end

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
